// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit queue.
//   txq_state_t : handshake FSM states of uart_tx_queue
//   TXQ_DEPTH   : default FIFO depth
//   TXQ_W       : default byte width (matches the serializer)
package uart_pkg;

  typedef enum logic [2:0] {
    SYNC,
    IDLE,
    ISSUE,
    WBUSY,
    WDONE
  } txq_state_t;

  localparam int TXQ_DEPTH = 16;
  localparam int TXQ_W     = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and sticky overflow flag.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en, wr_data    write strobe and data (dropped when full)
//   rd_en, rd_data    pop strobe; rd_data is a combinational view of the head
//   full, empty       count==DEPTH / count==0
//   count             entries held
//   overflow          sticky: write attempted while full
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // full is the pre-edge value, so a pop on the same edge never makes room
  // for a write that arrives while full.
  assign push    = wr_en & ~full;
  assign pop     = rd_en & ~empty;
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and count define
  // which entries are valid, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && full) overflow <= 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue and handshake controller feeding the UART transmit serializer.
// Core writes are buffered; bytes are issued one at a time with a one-cycle
// ready pulse, then the block waits for the serializer's done to fall and
// rise again before the next issue.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   wr_en, wr_data     core write strobe and byte
//   full, empty, count queue status (count excludes the byte in flight)
//   overflow           sticky: write seen while full
//   busy               queue non-empty or handshake in progress
//   as                 byte to serializer, held until the next issue
//   ready              one-cycle start pulse to serializer
//   done               serializer idle flag (1 = idle)
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH = TXQ_DEPTH,
  parameter int W     = TXQ_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [W-1:0]           wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   busy,
  output logic [W-1:0]           as,
  output logic                   ready,
  input  logic                   done
);

  txq_state_t   state;
  logic         rd_en;
  logic [W-1:0] rd_data;

  // Pop exactly on the edge that issues the head byte.
  assign rd_en = (state == IDLE) && !empty;
  assign busy  = !empty || (state != IDLE);

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  // The serializer is not reset with us, so after reset we sit in SYNC until
  // it reports idle; a frame in progress is never restarted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SYNC;
      as    <= '0;
      ready <= 1'b0;
    end else begin
      unique case (state)
        SYNC: begin
          ready <= 1'b0;
          if (done) state <= IDLE;
        end
        IDLE: begin
          if (!empty) begin
            as    <= rd_data;
            ready <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          ready <= 1'b0;
          state <= WBUSY;
        end
        WBUSY: begin
          if (!done) state <= WDONE;
        end
        WDONE: begin
          if (done) state <= IDLE;
        end
        default: begin
          ready <= 1'b0;
          state <= SYNC;
        end
      endcase
    end
  end

endmodule
